// File: rtl/enums_pkg.sv
// Shared machine-mode CSR types: trap causes, CSR addresses and the
// interrupt priority order used by the core's control path.
package enums;

    // mcause encodings; bit 31 marks an interrupt.
    typedef enum logic [31:0] {
        MCAUSE_INSTR_ADDR_MISALIGN = 32'h0000_0000,
        MCAUSE_INSTR_ACCESS_FAULT  = 32'h0000_0001,
        MCAUSE_ILLEGAL_INSTR       = 32'h0000_0002,
        MCAUSE_BREAKPOINT          = 32'h0000_0003,
        MCAUSE_LOAD_ADDR_MISALIGN  = 32'h0000_0004,
        MCAUSE_LOAD_ACCESS_FAULT   = 32'h0000_0005,
        MCAUSE_STORE_ADDR_MISALIGN = 32'h0000_0006,
        MCAUSE_STORE_ACCESS_FAULT  = 32'h0000_0007,
        MCAUSE_ECALL_M             = 32'h0000_000B,
        MCAUSE_MSI                 = 32'h8000_0003,
        MCAUSE_MTI                 = 32'h8000_0007,
        MCAUSE_MEI                 = 32'h8000_000B
    } mcause_t;

    // Machine-mode CSR addresses decoded by the csr access block.
    typedef enum logic [11:0] {
        CSR_MSTATUS       = 12'h300,
        CSR_MIE           = 12'h304,
        CSR_MTVEC         = 12'h305,
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MSCRATCH      = 12'h340,
        CSR_MEPC          = 12'h341,
        CSR_MCAUSE        = 12'h342,
        CSR_MTVAL         = 12'h343,
        CSR_MIP           = 12'h344,
        CSR_MCYCLE        = 12'hB00,
        CSR_MINSTRET      = 12'hB02,
        CSR_MCYCLEH       = 12'hB80,
        CSR_MINSTRETH     = 12'hB82
    } csr_t;

    // Interrupt priority, highest first.
    localparam int IRQ_NUM = 3;
    localparam mcause_t IRQ_PRIORITY [IRQ_NUM] = '{MCAUSE_MEI, MCAUSE_MSI, MCAUSE_MTI};

endpackage

// File: rtl/csr_state_counter.sv
// 64-bit free-running CSR counter; a load replaces the value outright and
// suppresses the increment for that cycle.
module csr_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        inhibit,
    input  logic        load,
    input  logic [63:0] load_val,
    output logic [63:0] count
);

    logic [63:0] count_next;

    // Load wins over increment; wrap at 2^64 is natural overflow.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = load_val;
        end else if (inc && !inhibit) begin
            count_next = count + 64'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 64'd0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/csr_state.sv
// Machine-mode CSR state holder and trap sequencer. Holds the architectural
// CSR fields, commits the csr block's write-back bus, runs mcycle/minstret,
// performs trap entry / mret and reports pending interrupts.
module csr_state
    import enums::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_we,
    input  logic        mie_next,
    input  logic        mpie_next,
    input  logic        mtie_next,
    input  logic        msie_next,
    input  logic        meie_next,
    input  logic [31:2] mtvec_base_next,
    input  logic [63:0] mcycle_next,
    input  logic [63:0] minstret_next,
    input  logic        mcycle_inhibit_next,
    input  logic        minstret_inhibit_next,
    input  logic [31:0] mscratch_next,
    input  logic [31:0] mepc_next,
    input  mcause_t     mcause_next,
    input  logic [31:0] mtval_next,
    output logic        mie,
    output logic        mpie,
    output logic        mtie,
    output logic        msie,
    output logic        meie,
    output logic [31:2] mtvec_base,
    output logic [63:0] mcycle,
    output logic [63:0] minstret,
    output logic        mcycle_inhibit,
    output logic        minstret_inhibit,
    output logic [31:0] mscratch,
    output logic [31:0] mepc,
    output logic [31:0] mtval,
    output mcause_t     mcause,
    input  logic        mtip,
    input  logic        msip,
    input  logic        meip,
    input  logic        instr_retired,
    input  logic        trap_req,
    input  mcause_t     trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret,
    output logic        irq_pending,
    output mcause_t     irq_cause,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    // A trap or mret in the same cycle swallows the CSR write completely.
    logic csr_commit;
    assign csr_commit = csr_we && !trap_req && !mret;

    // Index 0 = mcycle, index 1 = minstret.
    logic [1:0]  cnt_inc;
    logic [1:0]  cnt_inhibit;
    logic [63:0] cnt_load_val [2];
    logic [63:0] cnt_value [2];

    assign cnt_inc         = {instr_retired && !trap_req, 1'b1};
    assign cnt_inhibit     = {minstret_inhibit, mcycle_inhibit};
    assign cnt_load_val[0] = mcycle_next;
    assign cnt_load_val[1] = minstret_next;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            csr_counter u_cnt (
                .clk      (clk),
                .rst_n    (rst_n),
                .inc      (cnt_inc[gi]),
                .inhibit  (cnt_inhibit[gi]),
                .load     (csr_commit),
                .load_val (cnt_load_val[gi]),
                .count    (cnt_value[gi])
            );
        end
    endgenerate

    assign mcycle   = cnt_value[0];
    assign minstret = cnt_value[1];

    // Architectural state and redirect pulse: trap > mret > CSR write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie              <= 1'b0;
            mpie             <= 1'b0;
            mtie             <= 1'b0;
            msie             <= 1'b0;
            meie             <= 1'b0;
            mtvec_base       <= RESET_MTVEC[31:2];
            mcycle_inhibit   <= 1'b0;
            minstret_inhibit <= 1'b0;
            mscratch         <= 32'd0;
            mepc             <= 32'd0;
            mtval            <= 32'd0;
            mcause           <= MCAUSE_INSTR_ADDR_MISALIGN;
            redirect_valid   <= 1'b0;
            redirect_pc      <= 32'd0;
        end else begin
            redirect_valid <= 1'b0;
            if (trap_req) begin
                mepc           <= {trap_pc[31:2], 2'b00};
                mcause         <= trap_cause;
                mtval          <= trap_val;
                mpie           <= mie;
                mie            <= 1'b0;
                redirect_valid <= 1'b1;
                redirect_pc    <= {mtvec_base, 2'b00};
            end else if (mret) begin
                mie            <= mpie;
                mpie           <= 1'b1;
                redirect_valid <= 1'b1;
                redirect_pc    <= mepc;
            end else if (csr_we) begin
                mie              <= mie_next;
                mpie             <= mpie_next;
                mtie             <= mtie_next;
                msie             <= msie_next;
                meie             <= meie_next;
                mtvec_base       <= mtvec_base_next;
                mcycle_inhibit   <= mcycle_inhibit_next;
                minstret_inhibit <= minstret_inhibit_next;
                mscratch         <= mscratch_next;
                mepc             <= mepc_next;
                mcause           <= mcause_next;
                mtval            <= mtval_next;
            end
        end
    end

    // Zero-latency interrupt status from registered enables and raw lines.
    assign irq_pending = mie && ((meip && meie) || (msip && msie) || (mtip && mtie));

    // Highest-priority pending enabled interrupt; MEI when none pending.
    always_comb begin
        irq_cause = MCAUSE_MEI;
        if (meip && meie) begin
            irq_cause = MCAUSE_MEI;
        end else if (msip && msie) begin
            irq_cause = MCAUSE_MSI;
        end else if (mtip && mtie) begin
            irq_cause = MCAUSE_MTI;
        end
    end

endmodule

// File: tb/tb_csr_state.sv
// Scoreboard bench for csr_state: the driver applies directed and random
// stimulus, a behavioural model pushes the expected post-edge state into a
// queue, and an independent monitor pops and compares.
module tb_csr_state;
    import enums::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        csr_we, mie_next, mpie_next, mtie_next, msie_next, meie_next;
    logic [31:2] mtvec_base_next;
    logic [63:0] mcycle_next, minstret_next;
    logic        mcycle_inhibit_next, minstret_inhibit_next;
    logic [31:0] mscratch_next, mepc_next, mtval_next;
    mcause_t     mcause_next;
    logic        mie, mpie, mtie, msie, meie;
    logic [31:2] mtvec_base;
    logic [63:0] mcycle, minstret;
    logic        mcycle_inhibit, minstret_inhibit;
    logic [31:0] mscratch, mepc, mtval;
    mcause_t     mcause;
    logic        mtip, msip, meip, instr_retired, trap_req, mret;
    mcause_t     trap_cause;
    logic [31:0] trap_pc, trap_val;
    logic        irq_pending;
    mcause_t     irq_cause;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    csr_state #(.RESET_MTVEC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .csr_we(csr_we),
        .mie_next(mie_next), .mpie_next(mpie_next), .mtie_next(mtie_next),
        .msie_next(msie_next), .meie_next(meie_next), .mtvec_base_next(mtvec_base_next),
        .mcycle_next(mcycle_next), .minstret_next(minstret_next),
        .mcycle_inhibit_next(mcycle_inhibit_next), .minstret_inhibit_next(minstret_inhibit_next),
        .mscratch_next(mscratch_next), .mepc_next(mepc_next), .mcause_next(mcause_next),
        .mtval_next(mtval_next),
        .mie(mie), .mpie(mpie), .mtie(mtie), .msie(msie), .meie(meie),
        .mtvec_base(mtvec_base), .mcycle(mcycle), .minstret(minstret),
        .mcycle_inhibit(mcycle_inhibit), .minstret_inhibit(minstret_inhibit),
        .mscratch(mscratch), .mepc(mepc), .mtval(mtval), .mcause(mcause),
        .mtip(mtip), .msip(msip), .meip(meip), .instr_retired(instr_retired),
        .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_val(trap_val), .mret(mret), .irq_pending(irq_pending),
        .irq_cause(irq_cause), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mie, mpie, mtie, msie, meie;
        logic [29:0] mtvec_base;
        logic [63:0] mcycle, minstret;
        logic        cinh, iinh;
        logic [31:0] mscratch, mepc, mtval;
        mcause_t     mcause;
        logic        rv;
        logic [31:0] rpc;
        logic        chk_rpc;
        logic        irq_p;
        mcause_t     irq_c;
    } snap_t;

    snap_t m;
    snap_t exp_q [$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    n_push  = 0;
    int    n_pop   = 0;

    mcause_t causes [12] = '{MCAUSE_INSTR_ADDR_MISALIGN, MCAUSE_INSTR_ACCESS_FAULT,
        MCAUSE_ILLEGAL_INSTR, MCAUSE_BREAKPOINT, MCAUSE_LOAD_ADDR_MISALIGN,
        MCAUSE_LOAD_ACCESS_FAULT, MCAUSE_STORE_ADDR_MISALIGN, MCAUSE_STORE_ACCESS_FAULT,
        MCAUSE_ECALL_M, MCAUSE_MSI, MCAUSE_MTI, MCAUSE_MEI};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Interrupt view of a state given the raw lines currently driven.
    function automatic snap_t with_irq(snap_t s);
        logic e, sw, t;
        e  = meip && s.meie;
        sw = msip && s.msie;
        t  = mtip && s.mtie;
        s.irq_p = s.mie && (e || sw || t);
        s.irq_c = e ? MCAUSE_MEI : sw ? MCAUSE_MSI : t ? MCAUSE_MTI : MCAUSE_MEI;
        return s;
    endfunction

    function automatic snap_t reset_snap();
        snap_t s;
        s.mie = 0; s.mpie = 0; s.mtie = 0; s.msie = 0; s.meie = 0;
        s.mtvec_base = 30'h40;              // 0x100 >> 2
        s.mcycle = 0; s.minstret = 0; s.cinh = 0; s.iinh = 0;
        s.mscratch = 0; s.mepc = 0; s.mtval = 0;
        s.mcause = MCAUSE_INSTR_ADDR_MISALIGN;
        s.rv = 0; s.rpc = 0; s.chk_rpc = 1;
        s.irq_p = 0; s.irq_c = MCAUSE_MEI;
        return s;
    endfunction

    task automatic push(input snap_t s);
        m = with_irq(s);
        exp_q.push_back(m);
        n_push++;
    endtask

    // Reference behaviour for one rising edge, from the architectural rules.
    task automatic model_step();
        snap_t n;
        logic  commit;
        if (!rst_n) begin
            n = reset_snap();
        end else begin
            n = m;
            n.rv = 0;
            n.chk_rpc = 0;
            commit = csr_we && !trap_req && !mret;
            if (commit) begin
                n.mcycle   = mcycle_next;
                n.minstret = minstret_next;
            end else begin
                if (!m.cinh) n.mcycle = m.mcycle + 64'd1;
                if (!m.iinh && instr_retired && !trap_req) n.minstret = m.minstret + 64'd1;
            end
            if (trap_req) begin
                n.mepc = trap_pc & 32'hFFFF_FFFC;
                n.mcause = trap_cause;
                n.mtval = trap_val;
                n.mpie = m.mie;
                n.mie = 0;
                n.rv = 1; n.rpc = {m.mtvec_base, 2'b00}; n.chk_rpc = 1;
            end else if (mret) begin
                n.mie = m.mpie;
                n.mpie = 1;
                n.rv = 1; n.rpc = m.mepc; n.chk_rpc = 1;
            end else if (commit) begin
                n.mie = mie_next; n.mpie = mpie_next; n.mtie = mtie_next;
                n.msie = msie_next; n.meie = meie_next; n.mtvec_base = mtvec_base_next;
                n.cinh = mcycle_inhibit_next; n.iinh = minstret_inhibit_next;
                n.mscratch = mscratch_next; n.mepc = mepc_next;
                n.mcause = mcause_next; n.mtval = mtval_next;
            end
        end
        push(n);
    endtask

    // Monitor: compare whatever the DUT presents against the next expectation.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_pop++;
                chk("mie", 64'(mie), 64'(e.mie));
                chk("mpie", 64'(mpie), 64'(e.mpie));
                chk("mtie", 64'(mtie), 64'(e.mtie));
                chk("msie", 64'(msie), 64'(e.msie));
                chk("meie", 64'(meie), 64'(e.meie));
                chk("mtvec_base", 64'(mtvec_base), 64'(e.mtvec_base));
                chk("mcycle", mcycle, e.mcycle);
                chk("minstret", minstret, e.minstret);
                chk("mcycle_inhibit", 64'(mcycle_inhibit), 64'(e.cinh));
                chk("minstret_inhibit", 64'(minstret_inhibit), 64'(e.iinh));
                chk("mscratch", 64'(mscratch), 64'(e.mscratch));
                chk("mepc", 64'(mepc), 64'(e.mepc));
                chk("mtval", 64'(mtval), 64'(e.mtval));
                chk("mcause", 64'(mcause), 64'(e.mcause));
                chk("redirect_valid", 64'(redirect_valid), 64'(e.rv));
                if (e.chk_rpc) chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
                chk("irq_pending", 64'(irq_pending), 64'(e.irq_p));
                chk("irq_cause", 64'(irq_cause), 64'(e.irq_c));
            end
        end
    end

    task automatic load_next();
        mie_next = m.mie; mpie_next = m.mpie; mtie_next = m.mtie;
        msie_next = m.msie; meie_next = m.meie; mtvec_base_next = m.mtvec_base;
        mcycle_next = m.mcycle; minstret_next = m.minstret;
        mcycle_inhibit_next = m.cinh; minstret_inhibit_next = m.iinh;
        mscratch_next = m.mscratch; mepc_next = m.mepc;
        mcause_next = m.mcause; mtval_next = m.mtval;
    endtask

    task automatic clear_ctrl();
        csr_we = 0; trap_req = 0; mret = 0; instr_retired = 0;
        mtip = 0; msip = 0; meip = 0;
        trap_cause = MCAUSE_INSTR_ADDR_MISALIGN; trap_pc = 0; trap_val = 0;
    endtask

    // One clock: model follows the edge, inputs may change at negedge+2.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #2;
    endtask

    task automatic wr();
        csr_we = 1;
        step();
        csr_we = 0;
    endtask

    // Reset is asserted between edges so its asynchronous effect is visible.
    task automatic do_reset(input int cycles);
        clear_ctrl();
        push(reset_snap());
        rst_n = 0;
        repeat (cycles) step();
        rst_n = 1;
        load_next();
    endtask

    initial begin
        clear_ctrl();
        mie_next = 0; mpie_next = 0; mtie_next = 0; msie_next = 0; meie_next = 0;
        mtvec_base_next = 0; mcycle_next = 0; minstret_next = 0;
        mcycle_inhibit_next = 0; minstret_inhibit_next = 0;
        mscratch_next = 0; mepc_next = 0; mcause_next = MCAUSE_INSTR_ADDR_MISALIGN;
        mtval_next = 0;
        #2;
        do_reset(2);

        // Idle after reset: mcycle counts, nothing else moves.
        repeat (10) step();
        chk("idle_mcycle_10", mcycle, 64'd10);

        // Trap entry with interrupts enabled.
        load_next(); mie_next = 1; wr();
        trap_req = 1; trap_cause = MCAUSE_ILLEGAL_INSTR;
        trap_pc = 32'h0000_1236; trap_val = 32'hDEAD_BEEF;
        step();
        chk("trap_redirect_pc", 64'(redirect_pc), 64'h100);
        chk("trap_mepc", 64'(mepc), 64'h1234);
        clear_ctrl();
        step();

        // mret, then mret colliding with a CSR write.
        mret = 1; step(); mret = 0; step();
        load_next(); mscratch_next = 32'd5; csr_we = 1; mret = 1; step();
        clear_ctrl(); step();

        // Interrupt priority and masking.
        load_next(); mie_next = 1; meie_next = 1; mtie_next = 1; wr();
        meip = 1; mtip = 1; step();
        meip = 0; step();
        load_next(); mie_next = 0; wr();
        clear_ctrl();

        // Counter wrap, inhibit and load-without-increment.
        load_next(); mcycle_next = '1; wr();
        step();
        load_next(); mcycle_inhibit_next = 1; wr();
        repeat (5) step();
        load_next(); mcycle_inhibit_next = 0; wr();
        load_next(); mcycle_next = 64'h1_0000_0000; wr();
        step();

        // Retire on a trap cycle, then reset during the redirect pulse.
        instr_retired = 1; trap_req = 1; trap_cause = MCAUSE_ECALL_M; trap_pc = 32'h40;
        step();
        clear_ctrl();
        do_reset(2);
        step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            load_next();
            case ($urandom_range(0, 13))
                0: mie_next = ~m.mie;
                1: mpie_next = ~m.mpie;
                2: mtie_next = ~m.mtie;
                3: msie_next = ~m.msie;
                4: meie_next = ~m.meie;
                5: mtvec_base_next = 30'($urandom);
                6: mcycle_next = {($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom};
                7: minstret_next = {($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom};
                8: mcycle_inhibit_next = ~m.cinh;
                9: minstret_inhibit_next = ~m.iinh;
                10: mscratch_next = $urandom;
                11: mepc_next = $urandom & 32'hFFFF_FFFC;
                12: mcause_next = causes[$urandom_range(0, 11)];
                default: mtval_next = $urandom;
            endcase
            csr_we = ($urandom_range(0, 3) == 0);
            trap_req = ($urandom_range(0, 9) == 0);
            mret = ($urandom_range(0, 9) == 0);
            instr_retired = 1'($urandom_range(0, 1));
            mtip = 1'($urandom_range(0, 1));
            msip = 1'($urandom_range(0, 1));
            meip = 1'($urandom_range(0, 1));
            trap_cause = causes[$urandom_range(0, 11)];
            trap_pc = $urandom;
            trap_val = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                do_reset(1);
            end else begin
                step();
            end
        end
        clear_ctrl();
        step();

        chk("scoreboard_drained", 64'(n_pop), 64'(n_push));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/csr_state.md
# csr_state

Sequential machine-mode CSR state holder and trap sequencer. It registers every architectural CSR field that the combinational `csr` access block reads, and commits that block's `*_next` values on a CSR write. It also runs `mcycle`/`minstret`, performs trap entry and `mret` state updates, and reports pending interrupts to the core's control path. It sits directly beside `csr`, which is fed from these outputs and writes back into them, and beneath the core pipeline's execute/commit stage.

## Interface
- `RESET_MTVEC`, default `32'h0000_0100`: trap vector base after reset; bits [1:0] ignored.
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `csr_we` input 1: commit the `csr` block's `*_next` bus this cycle.
- `*_next` inputs from `csr`, each at the width of the matching state output below: `mie`, `mpie`, `mtie`, `msie`, `meie`, `mtvec_base`, `mcycle`, `minstret`, `mcycle_inhibit`, `minstret_inhibit`, `mscratch`, `mepc`, `mcause`, `mtval`.
- State outputs, registered, to `csr`:
  - `mie`, `mpie`, `mtie`, `msie`, `meie`: 1 each.
  - `mtvec_base` [31:2].
  - `mcycle`, `minstret`: 64 each.
  - `mcycle_inhibit`, `minstret_inhibit`: 1 each.
  - `mscratch`, `mepc`, `mtval`: 32 each.
  - `mcause`: `mcause_t`.
- `mtip`, `msip`, `meip` input 1 each: raw interrupt lines, already synchronous to `clk`.
- `instr_retired` input 1: one instruction retires this cycle.
- `trap_req` input 1: take a trap at the current instruction boundary.
- `trap_cause` input `mcause_t`: cause for `trap_req`. It is `irq_cause` for interrupts.
- `trap_pc` input 32: PC to save in `mepc`.
- `trap_val` input 32: value to save in `mtval`; 0 for interrupts.
- `mret` input 1: execute `mret`.
- `irq_pending` output 1: an enabled interrupt is pending and `mie`=1.
- `irq_cause` output `mcause_t`: highest-priority pending enabled interrupt.
- `redirect_valid` output 1: one-cycle fetch redirect pulse.
- `redirect_pc` output 32: redirect target.

## Operation
- Event priority per cycle: reset > `trap_req` > `mret` > `csr_we`.
  - A trap or `mret` drops a same-cycle `csr_we` entirely; no field is written from `*_next`.
  - `trap_req` together with `mret`: the trap is taken and `mret` is ignored.
- Trap entry:
  - `mepc` <= {`trap_pc`[31:2], 2'b00}; `mcause` <= `trap_cause`; `mtval` <= `trap_val`.
  - `mpie` <= `mie`; `mie` <= 0.
  - Redirect target is {`mtvec_base`, 2'b00}, using the pre-update `mtvec_base`.
- `mret`: `mie` <= `mpie`; `mpie` <= 1; redirect target is `mepc`.
- `csr_we`: every state register loads its `*_next` input. Fields the `csr` block did not address come back unchanged.
- `mcycle`: +1 per cycle when `mcycle_inhibit`=0.
- `minstret`: +1 when `instr_retired`=1, `minstret_inhibit`=0 and `trap_req`=0. `instr_retired` is ignored on a trap cycle.
- Counter write precedence:
  - On a `csr_we` that commits, both counters load `*_next` in full, 64 bits, with no increment that cycle. This applies to writes of `mcycleh`/`minstreth` as well.
  - The inhibit value used is the pre-write value.
- Counters wrap from 2^64-1 to 0 with no flag.
- Interrupts:
  - `irq_pending` = `mie` & ((`meip`&`meie`) | (`msip`&`msie`) | (`mtip`&`mtie`)).
  - `irq_cause` priority: MEI > MSI > MTI. `irq_cause` = MCAUSE_MEI when nothing is pending.
- Reset values:
  - `mie`, `mpie`, `mtie`, `msie`, `meie` = 0.
  - `mtvec_base` = `RESET_MTVEC`[31:2].
  - `mcycle`, `minstret` = 0; both inhibits = 0.
  - `mscratch`, `mepc`, `mtval` = 0; `mcause` = MCAUSE_INSTR_ADDR_MISALIGN (encoding 0).
  - `redirect_valid` = 0; `redirect_pc` = 0.

## Timing
- All state outputs reflect an event on the rising edge after the cycle in which it was presented. The `csr` block therefore sees committed values one cycle after `csr_we`.
- `redirect_valid`/`redirect_pc` are registered: they assert exactly one cycle after the accepted `trap_req`/`mret` cycle, for one cycle only.
- Back-to-back traps, or a trap immediately after `mret`, are legal. Each produces its own redirect pulse; a later pulse fully overrides an earlier target.
- `irq_pending`/`irq_cause` are combinational from registered enables and the raw lines, with zero latency. After a trap, `irq_pending` drops in the next cycle because `mie`=0.
- Reset asserted mid-operation clears all state immediately, including an in-flight `redirect_valid`. The first increment of `mcycle` occurs on the first edge after reset deassertion.

## Structure
- `mcause_t`, `csr_t` and the MCAUSE_* values live in `enums`. The interrupt priority order is added there as a constant list for reuse by the core.
- One sub-module, `csr_counter`:
  - 64-bit register with `inc`, `inhibit`, `load` and `load_val` inputs; load takes precedence over increment.
  - Instantiated twice, for `mcycle` and `minstret`.
- Everything else is flat.

## Test plan
- Reset release, then 10 idle cycles -> `mcycle`=10, `minstret`=0, `mtvec_base`=`RESET_MTVEC`[31:2], `redirect_valid` never high.
- `mie`=1, `trap_req` with cause MCAUSE_ILLEGAL_INSTR, `trap_pc`=0x0000_1236, `trap_val`=0xDEAD_BEEF -> next cycle:
  - `mepc`=0x1234, `mcause`=ILLEGAL_INSTR, `mtval`=0xDEADBEEF, `mpie`=1, `mie`=0.
  - One-cycle `redirect_valid` with `redirect_pc`=0x100.
- Then `mret` -> `mie`=1, `mpie`=1, redirect to 0x1234. `mret` with same-cycle `csr_we` writing `mscratch`=5 -> `mscratch` unchanged.
- `mie`=1, `meie`=`mtie`=1, `meip`=`mtip`=1 -> `irq_pending`=1, `irq_cause`=MCAUSE_MEI. Drop `meip` -> `irq_cause`=MCAUSE_MTI. Clear `mie` -> `irq_pending`=0.
- Preload `mcycle`=0xFFFF_FFFF_FFFF_FFFF -> wraps to 0 next cycle. With `mcycle_inhibit`=1 the value holds for 5 cycles. A `csr_we` loading 0x1_0000_0000 takes that value with no +1.
- `instr_retired`=1 together with `trap_req`=1 -> `minstret` unchanged. Assert `rst_n`=0 during a redirect pulse -> `redirect_valid` drops at once and all outputs return to their reset values.
